multiples_sum_gen: RTL
======================

Name: multiples_sum_gen

Overview:
- Parametrised successor to the fixed 3-and-5 summing block.
- Computes the sum of all k in [0, N) that are multiples of runtime divisor A or runtime divisor B. Each k is counted once, even when it is a multiple of both.
- Start/busy/done handshake; iterates one k per clock using residue counters, so no divider is needed.
- Sits behind the same st/busy control interface used by the existing top-level.

Parameters:
- IN_W, 16, width of the limit N.
- OUT_W, 32, width of the result accumulator and output.
- DIV_W, 8, width of each divisor.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st  in  1  start request; sampled only in IDLE.
- in  in  IN_W  limit N (exclusive upper bound).
- div_a  in  DIV_W  divisor A; 0 disables channel A.
- div_b  in  DIV_W  divisor B; 0 disables channel B.
- busy  out  1  high while a computation runs.
- done  out  1  one-cycle pulse when out is updated.
- ovf  out  1  sticky for the run: the sum exceeded OUT_W bits.
- out  out  OUT_W  result; held until the next done.

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, ovf, out, k, accumulator and residues all go to 0. Reset mid-run aborts the run with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - st=1 at a clock edge latches in, div_a and div_b.
  - Clears k, ra, rb, accumulator and ovf; enters RUN.
  - busy=1 from the following cycle.
- RUN, each cycle:
  - hit = (div_a!=0 && ra==0) || (div_b!=0 && rb==0).
  - On hit, acc += k.
  - ra advances to 0 when ra==div_a-1, else ra+1; rb likewise.
  - k increments.
- RUN exit: on the edge that processes k=N-1, go to DONE. For N=0, RUN lasts one cycle and adds nothing.
  - busy is high for exactly max(N,1) cycles.
- DONE (one cycle):
  - busy=0, done=1.
  - out and ovf take their final values at the same edge done rises.
  - Next state IDLE.
  - st asserted during DONE is ignored; st is accepted only from IDLE, so back-to-back starts are separated by one cycle.
- st asserted while busy is ignored; latched operands cannot change mid-run.
- Divisor 1 matches every k. Both divisors 0 gives result 0 after max(N,1) cycles.
- Overflow: the accumulator is OUT_W+1 bits internally. Any carry out of OUT_W sets ovf. The default (wrap) behaviour is given under Optional Feature.

Optional Feature:
- Macro: MULTSUM_SAT_EN.
- Defined: on the first overflow, out latches all-ones at done and further adds are suppressed; ovf=1.
- Undefined: the sum wraps modulo 2^OUT_W; ovf is still reported.

Decomposition:
- Package multsum_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default width constants IN_W_D=16, OUT_W_D=32, DIV_W_D=8.
- Sub-module mod_counter: a DIV_W residue counter with clr, en, divisor input and a zero flag. It is instantiated twice (channels A and B).

Test Plan:
- div 3/5, N=2 -> out=0, busy high 2 cycles, single done pulse.
- div 3/5, N=10 -> 23; N=20 -> 78; N=45 -> 450; N=1000 -> 233168, ovf=0.
- div_a=4, div_b=6, N=13 -> 30 (12 counted once); div_a=1, div_b=0, N=10 -> 45; both divisors 0 -> 0.
- N=0 -> out=0 after 1 busy cycle; st pulsed mid-run with a new in -> ignored, original result unchanged.
- OUT_W=16, div 3/5, N=1000 -> out=36560, ovf=1 without the macro; out=65535, ovf=1 with MULTSUM_SAT_EN.
- rst asserted mid-run at N=45 -> busy, out and done are 0 immediately; a restart yields 450.

Source files
------------

// File: rtl/multsum_pkg.sv
// ----------------------------------------------------------------------------
// multsum_pkg
// Shared definitions for the multiples-sum generator:
//   - state_t      : controller states IDLE / RUN / DONE
//   - IN_W_D       : default width of the limit N
//   - OUT_W_D      : default width of the result
//   - DIV_W_D      : default width of each divisor
// ----------------------------------------------------------------------------
package multsum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IN_W_D  = 16;
    localparam int OUT_W_D = 32;
    localparam int DIV_W_D = 8;

endpackage

// File: rtl/multiples_sum_gen_mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
// Residue counter modulo a runtime divisor. It tracks k mod div so the
// top-level can tell whether k is a multiple of div without a divider.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   clr_i   : synchronous clear back to residue 0 (start of a run)
//   en_i    : advance the residue by one
//   div_i   : divisor; a value of 0 lets the counter wrap freely, the
//             owner ignores the channel in that case
//   zero_o  : residue is currently 0
// ----------------------------------------------------------------------------
module mod_counter
    import multsum_pkg::*;
#(
    parameter int DIV_W = DIV_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             zero_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next residue: wrap to 0 after reaching div-1. With div=1 the
    // terminal value is 0 itself, so the residue stays at 0 and every k hits.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == div_i - DIV_ONE) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_ONE;
            end
        end
    end

    // Residue register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multiples_sum_gen.sv
// ----------------------------------------------------------------------------
// multiples_sum_gen
// Sums every k in [0, N) that is a multiple of divisor A or divisor B, each
// k counted once. One k is processed per clock; divisibility comes from two
// residue counters rather than a divider.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, aborts a run without done
//   st_i     : start request, only honoured in IDLE
//   in_i     : limit N (exclusive)
//   div_a_i  : divisor A, 0 disables channel A
//   div_b_i  : divisor B, 0 disables channel B
//   busy_o   : high for max(N,1) cycles while the run is in progress
//   done_o   : one-cycle pulse, out_o/ovf_o updated on the same edge
//   ovf_o    : the run's sum did not fit in OUT_W bits
//   out_o    : result, held until the next done
// Build option:
//   MULTSUM_SAT_EN : when defined, the first overflow freezes the sum and
//                    the result is reported as all-ones; otherwise the sum
//                    wraps modulo 2^OUT_W.
// ----------------------------------------------------------------------------
module multiples_sum_gen
    import multsum_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int DIV_W = DIV_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_i,
    input  logic [IN_W-1:0]  in_i,
    input  logic [DIV_W-1:0] div_a_i,
    input  logic [DIV_W-1:0] div_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [OUT_W-1:0] out_o
);

    localparam logic [IN_W-1:0] IN_ONE = IN_W'(1);

    state_t           state_q,  state_d;
    logic [IN_W-1:0]  n_q,      n_d;
    logic [DIV_W-1:0] divA_q,   divA_d;
    logic [DIV_W-1:0] divB_q,   divB_d;
    logic [IN_W-1:0]  k_q,      k_d;
    logic [OUT_W-1:0] acc_q,    acc_d;
    logic             runOvf_q, runOvf_d;
    logic [OUT_W-1:0] outVal_q, outVal_d;
    logic             ovfOut_q, ovfOut_d;

    logic             startRun;
    logic             zeroA;
    logic             zeroB;
    logic             hit;
    logic             lastK;
    logic [OUT_W:0]   kExt;
    logic [OUT_W:0]   addSum;

    assign startRun = (state_q == IDLE) && st_i;

    mod_counter #(.DIV_W(DIV_W)) u_resA (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (startRun),
        .en_i   (state_q == RUN),
        .div_i  (divA_q),
        .zero_o (zeroA)
    );

    mod_counter #(.DIV_W(DIV_W)) u_resB (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (startRun),
        .en_i   (state_q == RUN),
        .div_i  (divB_q),
        .zero_o (zeroB)
    );

    assign hit = ((divA_q != '0) && zeroA) || ((divB_q != '0) && zeroB);

    // N=0 still spends one RUN cycle; its k=0 adds nothing either way.
    assign lastK = (n_q == '0) || (k_q == n_q - IN_ONE);

    // One extra bit on the adder exposes the carry out of OUT_W.
    assign kExt   = (OUT_W + 1)'(k_q);
    assign addSum = {1'b0, acc_q} + kExt;

    // Controller: operand latch on start, one accumulate step per RUN
    // cycle, result and overflow published on the edge that enters DONE.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        divA_d   = divA_q;
        divB_d   = divB_q;
        k_d      = k_q;
        acc_d    = acc_q;
        runOvf_d = runOvf_q;
        outVal_d = outVal_q;
        ovfOut_d = ovfOut_q;

        case (state_q)
            IDLE: begin
                if (st_i) begin
                    n_d      = in_i;
                    divA_d   = div_a_i;
                    divB_d   = div_b_i;
                    k_d      = '0;
                    acc_d    = '0;
                    runOvf_d = 1'b0;
                    ovfOut_d = 1'b0;
                    state_d  = RUN;
                end
            end

            RUN: begin
`ifdef MULTSUM_SAT_EN
                // Once saturated the sum is frozen; the result is all-ones.
                if (hit && !runOvf_q) begin
                    acc_d    = addSum[OUT_W-1:0];
                    runOvf_d = addSum[OUT_W];
                end
`else
                if (hit) begin
                    acc_d    = addSum[OUT_W-1:0];
                    runOvf_d = runOvf_q | addSum[OUT_W];
                end
`endif
                k_d = k_q + IN_ONE;
                if (lastK) begin
                    state_d  = DONE;
                    ovfOut_d = runOvf_d;
`ifdef MULTSUM_SAT_EN
                    outVal_d = runOvf_d ? '1 : acc_d;
`else
                    outVal_d = acc_d;
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            divA_q   <= '0;
            divB_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            runOvf_q <= 1'b0;
            outVal_q <= '0;
            ovfOut_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            divA_q   <= divA_d;
            divB_q   <= divB_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            runOvf_q <= runOvf_d;
            outVal_q <= outVal_d;
            ovfOut_q <= ovfOut_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign ovf_o  = ovfOut_q;
    assign out_o  = outVal_q;

endmodule
